// File: rtl/fetch_branch_unit.sv
// LEGv8 fetch/branch unit: PC, req/ack instruction fetch, NZVC flags, next-PC selection.
// Optional macro FBU_PERF_COUNTERS_EN adds retired-instruction and taken-branch counters.
module fetch_branch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [10:0]       opCode,
  output logic              instr_valid,
  input  logic              advance,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic              CBZ,
  input  logic              bLT,
  input  logic              zero,
  input  logic              flag_we,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_c,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags
`ifdef FBU_PERF_COUNTERS_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       taken_count
`endif
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t            state;
  logic              take;
  logic [ADDR_W-1:0] cond_off;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] next_pc;

  // Word offsets: CB-format imm19 and B-format imm26, sign-extended and scaled by 4.
  assign cond_off = {{(ADDR_W-21){instr[23]}}, instr[23:5], 2'b00};
  assign br_off   = {{(ADDR_W-28){instr[25]}}, instr[25:0], 2'b00};

  // B.LT reads the registered flags (an earlier instruction), never the live ALU flags.
  assign take    = BrTaken & (UncondBr | (CBZ & zero) | (bLT & (flags[3] ^ flags[1])));
  assign next_pc = pc + (take ? (UncondBr ? br_off : cond_off) : ADDR_W'(4));

  // NOTE: reset gates the request combinationally so no fetch is presented in the reset cycle.
  assign imem_req    = (state == FETCH) & ~reset;
  assign imem_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign opCode      = instr[31:21];

  // NOTE: reset is synchronous, so it lives inside the clocked block and wins over any ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      flags       <= '0;
`ifdef FBU_PERF_COUNTERS_EN
      instr_count <= '0;
      taken_count <= '0;
`endif
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (advance) begin
            pc    <= next_pc;
            state <= FETCH;
            if (flag_we) flags <= {alu_n, alu_z, alu_v, alu_c};
`ifdef FBU_PERF_COUNTERS_EN
            instr_count <= instr_count + 32'd1;
            if (take) taken_count <= taken_count + 32'd1;
`endif
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Self-checking bench for fetch_branch_unit: directed LEGv8 branch scenarios, then random
// traffic compared every cycle against a behavioural PC/flags model.
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [10:0] opCode;
  logic        instr_valid;
  logic        advance;
  logic        BrTaken, UncondBr, CBZ, bLT, zero, flag_we;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic [63:0] pc;
  logic [3:0]  flags;
`ifdef FBU_PERF_COUNTERS_EN
  logic [31:0] instr_count, taken_count;
`endif

  fetch_branch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opCode(opCode), .instr_valid(instr_valid), .advance(advance),
    .BrTaken(BrTaken), .UncondBr(UncondBr), .CBZ(CBZ), .bLT(bLT), .zero(zero),
    .flag_we(flag_we), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .pc(pc), .flags(flags)
`ifdef FBU_PERF_COUNTERS_EN
    , .instr_count(instr_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "executing" flag, current PC, latched word, NZVC.
  bit          m_exec;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [3:0]  m_flags;
  int unsigned m_icnt, m_tcnt;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    longint off;
    bit     lt, tk;
    if (reset) begin
      m_exec = 0; m_pc = 64'h0; m_instr = 32'h0; m_flags = 4'h0; m_icnt = 0; m_tcnt = 0;
    end else if (!m_exec) begin
      if (imem_ack) begin m_instr = imem_rdata; m_exec = 1; end
    end else if (advance) begin
      lt = m_flags[3] != m_flags[1];
      tk = BrTaken && (UncondBr || (CBZ && zero) || (bLT && lt));
      if (UncondBr) off = longint'($signed(m_instr[25:0])) * 4;
      else          off = longint'($signed(m_instr[23:5])) * 4;
      m_pc = tk ? m_pc + off : m_pc + 64'd4;
      if (flag_we) m_flags = {alu_n, alu_z, alu_v, alu_c};
      m_icnt++;
      if (tk) m_tcnt++;
      m_exec = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_req", imem_req, !m_exec && !reset);
      if (imem_req) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", instr_valid, m_exec);
      check("instr", instr, m_instr);
      check("opCode", opCode, m_instr[31:21]);
      check("pc", pc, m_pc);
      check("flags", flags, m_flags);
`ifdef FBU_PERF_COUNTERS_EN
      check("instr_count", instr_count, m_icnt);
      check("taken_count", taken_count, m_tcnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 0; imem_rdata = '0; advance = 0; BrTaken = 0; UncondBr = 0; CBZ = 0; bLT = 0;
    zero = 0; flag_we = 0; {alu_n, alu_z, alu_v, alu_c} = 4'h0;
  endtask

  // One instruction: optional fetch stall, ack, then a single EXEC cycle with advance.
  task automatic run_instr(input logic [31:0] word, input bit br, input bit unc, input bit cbz,
                           input bit blt, input bit z, input bit fwe, input logic [3:0] nzvc);
    clear_inputs();
    imem_ack = 1; imem_rdata = word;
    cyc();
    clear_inputs();
    advance = 1; BrTaken = br; UncondBr = unc; CBZ = cbz; bLT = blt; zero = z;
    flag_we = fwe; {alu_n, alu_z, alu_v, alu_c} = nzvc;
    cyc();
    clear_inputs();
  endtask

  localparam logic [31:0] NOP_ADD = 32'h8B020020;
  localparam logic [31:0] SUBS    = 32'hEB020020;

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    cmp_en = 1;
    cyc();
    reset = 0;

    // Same-cycle ack, advance on first EXEC cycle.
    imem_ack = 1; imem_rdata = NOP_ADD;
    cyc();
    imem_ack = 0;
    check("t1_opcode", opCode, 11'h458);
    check("t1_valid", instr_valid, 1'b1);
    advance = 1;
    cyc();
    advance = 0;
    check("t1_addr", imem_addr, 64'h4);
    check("t1_valid_low", instr_valid, 1'b0);

    // Delayed ack: request and address must hold.
    for (int i = 0; i < 5; i++) begin
      check("t2_req", imem_req, 1'b1);
      check("t2_addr", imem_addr, 64'h4);
      check("t2_valid", instr_valid, 1'b0);
      cyc();
    end
    run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    check("t3_pc_before_b", pc, 64'h10);
    run_instr(32'h17FFFFFC, 1, 1, 0, 0, 0, 0, 4'h0);
    check("t3_b_back", pc, 64'h0);

    for (int i = 0; i < 8; i++) run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    check("t4_pc_20", pc, 64'h20);
    run_instr(32'hB4000060, 1, 0, 1, 0, 1, 0, 4'h0);
    check("t4_cbz_taken", pc, 64'h2C);
    run_instr(32'h17FFFFFD, 1, 1, 0, 0, 0, 0, 4'h0);
    check("t4_b_minus3", pc, 64'h20);
    run_instr(32'hB4000060, 1, 0, 1, 0, 0, 0, 4'h0);
    check("t4_cbz_not", pc, 64'h24);

    run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    run_instr(SUBS, 0, 0, 0, 0, 0, 1, 4'b1000);
    check("t5_flags", flags, 4'b1000);
    check("t5_pc_30", pc, 64'h30);
    run_instr(32'h5400004B, 1, 0, 0, 1, 0, 0, 4'h0);
    check("t5_blt_taken", pc, 64'h38);
    run_instr(32'h17FFFFFD, 1, 1, 0, 0, 0, 0, 4'h0);
    run_instr(SUBS, 0, 0, 0, 0, 0, 1, 4'b1010);
    check("t5_flags_nv", flags, 4'b1010);
    run_instr(32'h5400004B, 1, 0, 0, 1, 0, 0, 4'h0);
    check("t5_blt_not", pc, 64'h34);

    // Reset during FETCH with a simultaneous ack.
    for (int i = 0; i < 3; i++) run_instr(NOP_ADD, 0, 0, 0, 0, 0, 0, 4'h0);
    check("t6_pc_40", pc, 64'h40);
    imem_ack = 1; imem_rdata = NOP_ADD; reset = 1;
    cyc();
    reset = 0; imem_ack = 0;
    check("t6_instr", instr, 32'h0);
    check("t6_pc", pc, 64'h0);
    check("t6_valid", instr_valid, 1'b0);
`ifdef FBU_PERF_COUNTERS_EN
    check("t6_icnt", instr_count, 32'h0);
    check("t6_tcnt", taken_count, 32'h0);
`endif

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(99) < 2);
      imem_ack   = $urandom_range(1);
      imem_rdata = $urandom;
      advance    = $urandom_range(1);
      BrTaken    = $urandom_range(1);
      UncondBr   = $urandom_range(1);
      CBZ        = $urandom_range(1);
      bLT        = $urandom_range(1);
      zero       = $urandom_range(1);
      flag_we    = $urandom_range(1);
      {alu_n, alu_z, alu_v, alu_c} = 4'($urandom);
      cyc();
    end
    clear_inputs();
    reset = 0;
    cyc();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
- Instruction-side counterpart of the opcode control decoder in the single-cycle LEGv8 core.
- Holds the PC and fetches 32-bit instructions over a req/ack handshake to instruction memory.
- Presents each instruction and its opCode[10:0] field to the decoder and keeps the NZVC flag register.
- Consumes the decoder's BrTaken/UncondBr/CBZ/bLT outputs to choose the next PC.

Parameters:
- ADDR_W, 64, PC and instruction address width.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request, held until imem_ack.
- imem_addr  output  ADDR_W  fetch address, equal to pc while imem_req is high.
- imem_ack  input  1  instruction data valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  input  32  instruction word, sampled when imem_req and imem_ack are both high.
- instr  output  32  latched instruction.
- opCode  output  11  instr[31:21], fed to the decoder.
- instr_valid  output  1  instr and opCode are valid and the core is executing.
- advance  input  1  core has finished the current instruction; honoured only while instr_valid is high.
- BrTaken, UncondBr, CBZ, bLT  input  1 each  control decoder outputs for the current instruction.
- zero  input  1  ALU zero result, used for CBZ.
- flag_we  input  1  current instruction sets the flags (ADDS/SUBS).
- alu_n, alu_z, alu_v, alu_c  input  1 each  ALU flag results.
- pc  output  ADDR_W  address of the current instruction.
- flags  output  4  registered {N,Z,V,C}.

Behaviour:
- Reset, synchronous: pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, flags=0.
  - imem_req reads 0 during the reset cycle and 1 in the first cycle after reset.
- FSM state FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, go to EXEC.
  - imem_ack without imem_req is ignored.
- FSM state EXEC:
  - instr_valid=1, imem_req=0.
  - advance=0: hold instr and pc indefinitely.
  - advance=1: pc<=next_pc, go to FETCH.
  - If flag_we is also high, flags<={alu_n,alu_z,alu_v,alu_c} on the same edge.
- Minimum 2 cycles per instruction (ack in the FETCH cycle, advance in the first EXEC cycle).
- Branch offsets:
  - cond_off = sign-extended instr[23:5], shifted left 2.
  - br_off = sign-extended instr[25:0], shifted left 2.
  - Both are extended to ADDR_W.
- take = BrTaken & (UncondBr | (CBZ & zero) | (bLT & (flags.N ^ flags.V))).
- next_pc = take ? pc + (UncondBr ? br_off : cond_off) : pc + 4.
  - Computed modulo 2^ADDR_W; wrap-around is silent.
- bLT uses the registered flags, i.e. flags from an earlier instruction, never the current ALU flags.
- Control inputs are ignored outside EXEC & advance.
  - CBZ and bLT are not guaranteed mutually exclusive by the decoder; the OR above is authoritative.
- Reset mid-fetch or mid-exec:
  - Outstanding request is abandoned; imem_ack in the reset cycle is discarded.
  - FSM restarts from FETCH at RESET_PC.

Optional Feature:
- Macro: FBU_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs instr_count [31:0] and taken_count [31:0], both reset to 0.
  - instr_count increments on every EXEC & advance.
  - taken_count increments when take is also high.
  - Both counters wrap at 2^32.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then imem_ack same-cycle, imem_rdata=0x8B020020, advance on first EXEC cycle -> opCode=0x458, instr_valid one cycle, next imem_addr=0x4, 2 cycles/instr.
- Delayed ack: hold imem_ack low 5 cycles -> imem_req and imem_addr=0x4 stable all 5 cycles, instr_valid stays 0.
- B at pc=0x10, instr=0x17FFFFFC (offset -4), BrTaken=1, UncondBr=1 -> next pc=0x0.
- CBZ at pc=0x20, instr[23:5]=3: zero=1 -> pc=0x2C; zero=0 -> pc=0x24.
- SUBS with alu_n=1, alu_v=0, flag_we=1, then B.LT, instr[23:5]=2, at pc=0x30 -> flags=4'b1000, pc=0x38; repeat with alu_n=1, alu_v=1 -> pc=0x34.
- reset asserted in FETCH with imem_ack=1 at pc=0x40 -> instr stays 0, pc=RESET_PC next cycle; with FBU_PERF_COUNTERS_EN, both counters read 0.
